// File: rtl/dm_video_packetizer.sv
// Camera pixel stream to RGB444 Avalon-ST packets through an elastic FIFO.
// Define DM_TEST_PATTERN_EN to enable the vertical colour-bar test pattern.
module dm_video_packetizer #(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cam_frame_start,
    input  logic        cam_valid,
    input  logic [11:0] cam_data,
    input  logic        test_mode,
    input  logic        ready_in,
    output logic        valid_out,
    output logic [11:0] data_out,
    output logic        startofpacket_out,
    output logic        endofpacket_out,
    output logic        overflow,
    output logic [7:0]  frames_dropped
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, TERM} state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;

    logic [13:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          full, empty, pop;
    logic          wr_en;
    logic [13:0]   wr_word;
    logic [13:0]   head;

    logic          sof;
    logic          px_take;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          px_sop, px_eop;
    logic [11:0]   px_data;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign pop   = !empty && ready_in;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // A pixel arriving with frame_start in WAIT_SOF is pixel 0 of the new frame.
    assign sof     = (state_q == WAIT_SOF) && cam_frame_start;
    assign px_take = cam_valid &&
                     (sof || (state_q == ACTIVE && !cam_frame_start));
    assign cx      = sof ? '0 : x_q;
    assign cy      = sof ? '0 : y_q;
    assign px_sop  = (cx == '0) && (cy == '0);
    assign px_eop  = (cx == X_LAST) && (cy == Y_LAST);

`ifdef DM_TEST_PATTERN_EN
    localparam int BAR_W = IMG_W / 8;
    logic       tp_q, tp_d;
    logic       ctp;
    logic [2:0] bar;

    assign ctp = sof ? test_mode : tp_q;

    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++) begin
            if (int'(cx) >= k * BAR_W) bar = 3'(k);
        end
    end

    always_comb begin
        px_data = cam_data;
        if (ctp) begin
            unique case (bar)
                3'd0: px_data = 12'hFFF;
                3'd1: px_data = 12'hFF0;
                3'd2: px_data = 12'h0FF;
                3'd3: px_data = 12'h0F0;
                3'd4: px_data = 12'hF0F;
                3'd5: px_data = 12'hF00;
                3'd6: px_data = 12'h00F;
                3'd7: px_data = 12'h000;
            endcase
        end
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign px_data = cam_data;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        wr_en   = 1'b0;
        wr_word = '0;
`ifdef DM_TEST_PATTERN_EN
        tp_d    = tp_q;
`endif
        unique case (state_q)
            WAIT_SOF: begin
                if (cam_frame_start) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    ovf_d   = 1'b0;
`ifdef DM_TEST_PATTERN_EN
                    tp_d    = test_mode;
`endif
                end
            end
            ACTIVE: begin
                if (cam_frame_start) begin
                    drop_d  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                    state_d = px_sop ? WAIT_SOF : TERM;
                end
            end
            TERM: begin
                if (!full) begin
                    wr_en   = 1'b1;
                    wr_word = {1'b0, 1'b1, 12'h000};
                    state_d = WAIT_SOF;
                end
            end
            default: state_d = WAIT_SOF;
        endcase

        if (px_take) begin
            if (full) begin
                ovf_d   = 1'b1;
                drop_d  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                state_d = px_sop ? WAIT_SOF : TERM;
            end else begin
                wr_en   = 1'b1;
                wr_word = {px_sop, px_eop, px_data};
                if (px_eop) begin
                    state_d = WAIT_SOF;
                end else if (cx == X_LAST) begin
                    x_d = '0;
                    y_d = cy + 1'b1;
                end else begin
                    x_d = cx + 1'b1;
                    y_d = cy;
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_SOF;
            x_q      <= '0;
            y_q      <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
`ifdef DM_TEST_PATTERN_EN
            tp_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
`ifdef DM_TEST_PATTERN_EN
            tp_q     <= tp_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
    end

    assign valid_out         = !empty;
    assign data_out          = empty ? '0 : head[11:0];
    assign startofpacket_out = !empty && head[13];
    assign endofpacket_out   = !empty && head[12];
    assign overflow          = ovf_q;
    assign frames_dropped    = drop_q;

endmodule
